speed_level_ctrl: RTL and testbench

//  Game-speed sequencer driving the 4-bit level select of the modulo clock divider.

---
 rtl/game_pkg.sv | 17 +
 rtl/rise_pulse.sv | 22 ++
 rtl/speed_level_ctrl.sv | 113 +++++++++++
 tb/tb_speed_level_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the game-speed sequencer: FSM state codes and
// divider level-code limits.
package game_pkg;

  typedef logic [3:0] level_t;
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_RUN   = 2'b01;
  localparam state_t ST_PAUSE = 2'b10;
  localparam state_t ST_OVER  = 2'b11;

  localparam level_t LVL_MIN  = 4'd1;
  localparam level_t LVL_MAX  = 4'd10;
  localparam level_t LVL_TEST = 4'b1111;

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector: samples d_i every cycle and flags a 0->1 transition
// combinationally against the registered previous sample.
module rise_pulse (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/speed_level_ctrl.sv
// Game-speed sequencer: run/pause/over FSM, score-driven level stepping for the
// clock divider, and a settle-gated single-cycle game tick derived from the divider output.
module speed_level_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MIN_LEVEL     = 1,
  parameter int unsigned MAX_LEVEL     = 10,
  parameter int unsigned PTS_PER_LEVEL = 5,
  parameter int unsigned SETTLE_CYC    = 4,
  parameter int unsigned TEST_MODE     = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       score_evt_i,
  input  logic       fail_i,
  input  logic       div_clk_i,
  output logic [3:0] level_o,
  output logic       tick_en_o,
  output logic       level_up_o,
  output logic       game_over_o,
  output logic [1:0] state_o
);

  localparam int unsigned PtsW    = $clog2(PTS_PER_LEVEL + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);

  localparam logic [PtsW-1:0]    PtsLast   = PtsW'(PTS_PER_LEVEL - 1);
  localparam logic [SettleW-1:0] SettleMax = SettleW'(SETTLE_CYC);
  localparam level_t             LvlMin    = level_t'(MIN_LEVEL);
  localparam level_t             LvlMax    = level_t'(MAX_LEVEL);

  state_t              state_q, state_d;
  level_t              level_q, level_d;
  logic [PtsW-1:0]     pts_q, pts_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                tick_en_q, tick_en_d;
  logic                level_up_q, level_up_d;
  logic                game_over_q, game_over_d;
  logic                div_rise;

  rise_pulse u_div_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (div_clk_i),
    .rise_o (div_rise)
  );

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    pts_d      = pts_q;
    settle_d   = (settle_q != '0) ? settle_q - 1'b1 : settle_q;
    level_up_d = 1'b0;

    // Priority chain: Fail > Start > ScoreEvt > Pause.
    if (fail_i && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      state_d = ST_OVER;
    end else if (start_i) begin
      state_d  = ST_RUN;
      level_d  = LvlMin;
      pts_d    = '0;
      settle_d = SettleMax;
    end else if (score_evt_i && state_q == ST_RUN) begin
      if (pts_q == PtsLast) begin
        pts_d = '0;
        if (level_q < LvlMax) begin
          level_d    = level_q + 1'b1;
          level_up_d = 1'b1;
          settle_d   = SettleMax;
        end
      end else begin
        pts_d = pts_q + 1'b1;
      end
    end else if (pause_i && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (pause_i && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end

    // Ticks are suppressed while the divider reloads after a level change.
    tick_en_d   = (state_q == ST_RUN) && div_rise && (settle_q == '0);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      level_q     <= LvlMin;
      pts_q       <= '0;
      settle_q    <= '0;
      tick_en_q   <= 1'b0;
      level_up_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      pts_q       <= pts_d;
      settle_q    <= settle_d;
      tick_en_q   <= tick_en_d;
      level_up_q  <= level_up_d;
      game_over_q <= game_over_d;
    end
  end

  assign level_o     = (TEST_MODE != 0) ? LVL_TEST : level_q;
  assign tick_en_o   = tick_en_q;
  assign level_up_o  = level_up_q;
  assign game_over_o = game_over_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Bench for speed_level_ctrl: a normal and a TEST_MODE instance share directed
// stimulus and are checked every cycle against a points-based game model.
module tb_speed_level_ctrl;

  localparam int MinLvl = 1;
  localparam int MaxLvl = 10;
  localparam int Pts    = 5;
  localparam int Settle = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, score = 1'b0, fail = 1'b0, div = 1'b0;

  logic [3:0] level0, level1;
  logic       tick0, tick1, lvlup0, lvlup1, over0, over1;
  logic [1:0] state0, state1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_lvlup = 0;
  int n_ticks = 0;
  bit cmp_en  = 1'b0;

  // Model: game state (0 idle, 1 run, 2 pause, 3 over), points since last start,
  // edge index of the last level (re)load, and the registered pulse outputs.
  int m_state = 0, m_total = 0, m_edge = 0, m_chg = -100;
  bit m_prev_div = 1'b0, m_tick = 1'b0, m_lvlup = 1'b0;

  speed_level_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .score_evt_i(score),
    .fail_i(fail), .div_clk_i(div), .level_o(level0), .tick_en_o(tick0),
    .level_up_o(lvlup0), .game_over_o(over0), .state_o(state0)
  );

  speed_level_ctrl #(.TEST_MODE(1)) u_dut_tm (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .score_evt_i(score),
    .fail_i(fail), .div_clk_i(div), .level_o(level1), .tick_en_o(tick1),
    .level_up_o(lvlup1), .game_over_o(over1), .state_o(state1)
  );

  always #5 clk = ~clk;

  function automatic int lvl_of(input int total);
    int l;
    l = MinLvl + total / Pts;
    return (l > MaxLvl) ? MaxLvl : l;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int old;
    if (!rst_n) begin
      m_state = 0; m_total = 0; m_edge = 0; m_chg = -100;
      m_prev_div = 1'b0; m_tick = 1'b0; m_lvlup = 1'b0;
    end else begin
      m_edge++;
      m_tick = (m_state == 1) && div && !m_prev_div && (m_edge - m_chg > Settle);
      m_prev_div = div;
      m_lvlup = 1'b0;
      if (fail && (m_state == 1 || m_state == 2)) begin
        m_state = 3;
      end else if (start) begin
        m_state = 1; m_total = 0; m_chg = m_edge;
      end else if (score && m_state == 1) begin
        old = lvl_of(m_total);
        m_total++;
        if (lvl_of(m_total) != old) begin
          m_lvlup = 1'b1; m_chg = m_edge;
        end
      end else if (pause && m_state == 1) begin
        m_state = 2;
      end else if (pause && m_state == 2) begin
        m_state = 1;
      end
    end
  endtask

  task automatic compare_cycle();
    if (rst_n && cmp_en) begin
      check("state", int'(state0), m_state);
      check("level", int'(level0), lvl_of(m_total));
      check("tick_en", int'(tick0), int'(m_tick));
      check("level_up", int'(lvlup0), int'(m_lvlup));
      check("game_over", int'(over0), int'(m_state == 3));
      check("tm_level", int'(level1), 15);
      check("tm_state", int'(state1), m_state);
      check("tm_tick_en", int'(tick1), int'(m_tick));
      check("tm_level_up", int'(lvlup1), int'(m_lvlup));
      check("tm_game_over", int'(over1), int'(m_state == 3));
      if (lvlup0) n_lvlup++;
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic sc, input logic f);
    start = s; pause = p; score = sc; fail = f;
    @(posedge clk); #2;
    start = 1'b0; pause = 1'b0; score = 1'b0; fail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, int'(state0), 0);
    check({tag, "_level"}, int'(level0), 1);
    check({tag, "_tick"}, int'(tick0), 0);
    check({tag, "_lvlup"}, int'(lvlup0), 0);
    check({tag, "_over"}, int'(over0), 0);
    check({tag, "_tm_level"}, int'(level1), 15);
  endtask

  initial begin
    int got;
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        model_step();
      end
      forever begin
        @(negedge clk);
        compare_cycle();
      end
      forever begin
        repeat (8) @(posedge clk);
        #2 div = ~div;
      end
    join_none

    // Reset state
    idle(3);
    #1 check_reset_outputs("rst");
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Non-start inputs in IDLE are ignored
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1 check("idle_hold_state", int'(state0), 0);

    // T2: start, then exactly four ticks in any 64-cycle window past settling
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("start_state", int'(state0), 1);
    idle(8);
    n_ticks = 0;
    repeat (64) begin
      @(negedge clk);
      if (tick0) n_ticks++;
    end
    check("tick_count_64", n_ticks, 4);
    @(posedge clk); #2;

    // T3: first level step, then saturation at 10
    n_lvlup = 0;
    repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("lvl_after5", int'(level0), 2);
    check("lvlup_after5", int'(lvlup0), 1);
    check("tm_lvlup_after5", int'(lvlup1), 1);
    check("tm_level_after5", int'(level1), 15);
    repeat (45) drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    #1 check("lvl_saturated", int'(level0), 10);
    check("lvlup_total", n_lvlup, 9);

    // T4: pause holds points; T5: Fail beats ScoreEvt at the level boundary
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("pause_state", int'(state0), 2);
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("resume_state", int'(state0), 1);
    check("resume_level", int'(level0), 1);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("pts4_level", int'(level0), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    #1 check("fail_state", int'(state0), 3);
    check("fail_level", int'(level0), 1);
    check("fail_over", int'(over0), 1);
    check("fail_lvlup", int'(lvlup0), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("restart_state", int'(state0), 1);
    check("restart_level", int'(level0), 1);
    check("restart_over", int'(over0), 0);

    // T1: asynchronous reset while a tick is high
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (tick0) begin
        got = 1;
        break;
      end
    end
    check("t1_tick_seen", got, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    idle(2);
    #1 rst_n = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
